// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extraction and sign/zero extension,
// delivered through a valid/ready output register backed by a one-entry skid.
module imm_extend_pipe #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [2:0]      in_fmt,
    input  logic            in_uns,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    generate
        if (ILEN != 32 || (XLEN != 32 && XLEN != 64)) begin : g_bad_params
            $error("imm_extend_pipe: ILEN must be 32 and XLEN must be 32 or 64");
        end
    endgenerate

    // Occupancy of the output stage plus skid entry
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } occ_t;

    occ_t            state;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    logic            sgn;
    logic            take_in;
    logic            take_out;

    // The opcode bits never contribute to any immediate
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    assign take_in  = in_valid & in_ready;
    assign take_out = out_valid & out_ready;

    // Extract the field for the selected format and extend it to XLEN
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        // I, S, B and J all carry their field MSB in instr[31]
        sgn     = ~in_uns & in_instr[31];
        case (in_fmt)
            3'd0: ext_imm = {{(XLEN-12){sgn}}, in_instr[31:20]};
            3'd1: ext_imm = {{(XLEN-12){sgn}}, in_instr[31:25], in_instr[11:7]};
            3'd2: ext_imm = {{(XLEN-13){sgn}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            3'd3: ext_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            3'd4: ext_imm = {{(XLEN-21){sgn}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            3'd5: ext_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            default: begin
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    // Occupancy FSM driving the output stage, skid entry and in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_err   <= 1'b0;
            skid_imm  <= '0;
            skid_err  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (take_in) begin
                        out_valid <= 1'b1;
                        out_imm   <= ext_imm;
                        out_err   <= ext_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (take_out && take_in) begin
                        out_imm <= ext_imm;
                        out_err <= ext_err;
                    end else if (take_out) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (take_in) begin
                        skid_imm <= ext_imm;
                        skid_err <= ext_err;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (take_out) begin
                        out_imm  <= skid_imm;
                        out_err  <= skid_err;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: drives a 32-bit and a 64-bit instance with identical
// stimulus and checks both against a reference model through a scoreboard.
module tb_imm_extend_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        in_uns;

    logic        ir32, ov32, oe32;
    logic [31:0] oi32;
    logic        ir64, ov64, oe64;
    logic [63:0] oi64;

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    exp_t q[$];

    logic        hold_chk = 1'b0;
    logic [31:0] h32;
    logic [63:0] h64;
    logic        he;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .ILEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_uns(in_uns),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(oi32), .out_err(oe32)
    );

    imm_extend_pipe #(.XLEN(64), .ILEN(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_uns(in_uns),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(oi64), .out_err(oe64)
    );

    // Reference: left-align the field, then shift back arithmetically or logically
    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] f, input logic u);
        exp_t        r;
        logic [31:0] fld;
        logic [63:0] t;
        int          w;
        logic        se;
        r.err = 1'b0;
        se    = !u;
        case (f)
            3'd0: begin fld = {20'b0, ins[31:20]}; w = 12; end
            3'd1: begin fld = {20'b0, ins[31:25], ins[11:7]}; w = 12; end
            3'd2: begin fld = {19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; w = 13; end
            3'd3: begin fld = {ins[31:12], 12'b0}; w = 32; se = 1'b1; end
            3'd4: begin fld = {11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; w = 21; end
            3'd5: begin fld = {27'b0, ins[19:15]}; w = 5; se = 1'b0; end
            default: begin fld = '0; w = 32; se = 1'b0; r.err = 1'b1; end
        endcase
        t = {32'b0, fld} << (64 - w);
        if (se) r.imm = $signed(t) >>> (64 - w);
        else    r.imm = t >> (64 - w);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send(input logic [31:0] i, input logic [2:0] f, input logic u);
        logic acc;
        in_valid = 1'b1;
        in_instr = i;
        in_fmt   = f;
        in_uns   = u;
        acc      = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = ir32;
            tick();
        end
        chk("send_accept", {63'b0, acc}, 64'd1);
        in_valid = 1'b0;
        in_instr = $urandom;
        in_fmt   = 3'($urandom_range(0, 7));
        in_uns   = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard monitor: sampled mid-cycle, reflects what transfers on the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (ir32 === ir64 && ov32 === ov64) else begin
                errors++;
                $error("FAIL hs_match ir32=%b ir64=%b ov32=%b ov64=%b", ir32, ir64, ov32, ov64);
            end
            if (hold_chk && ov32) begin
                checks++;
                assert (oi32 === h32 && oi64 === h64 && oe32 === he) else begin
                    errors++;
                    $error("FAIL hold_stable got=%h/%h/%b exp=%h/%h/%b", oi32, oi64, oe32, h32, h64, he);
                end
            end
            if (ov32 && out_ready) begin
                exp_t e;
                pops++;
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow got=%h exp=empty", oi64);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    assert (oi64 === e.imm) else begin
                        errors++;
                        $error("FAIL sb_imm64 got=%h exp=%h", oi64, e.imm);
                    end
                    checks++;
                    assert (oi32 === e.imm[31:0]) else begin
                        errors++;
                        $error("FAIL sb_imm32 got=%h exp=%h", oi32, e.imm[31:0]);
                    end
                    checks++;
                    assert (oe32 === e.err && oe64 === e.err) else begin
                        errors++;
                        $error("FAIL sb_err got=%b/%b exp=%b", oe32, oe64, e.err);
                    end
                end
            end
            if (in_valid && ir32) q.push_back(model(in_instr, in_fmt, in_uns));
            hold_chk = ov32 && !out_ready;
            h32 = oi32;
            h64 = oi64;
            he  = oe32;
        end else begin
            hold_chk = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int   start;
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_fmt    = '0;
        in_uns    = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", {63'b0, ov32}, 64'd0);
        chk("rst_imm64", oi64, 64'd0);
        chk("rst_err", {63'b0, oe32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {63'b0, ir32}, 64'd1);
        chk("rst_valid_post", {63'b0, ov32}, 64'd0);

        // Directed single transfers with free-running consumer
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, 1'b0);
        chk("i_valid", {63'b0, ov32}, 64'd1);
        chk("i_imm32", {32'b0, oi32}, 64'h0000_0000_FFFF_FFFF);
        chk("i_err", {63'b0, oe32}, 64'd0);
        send(32'hFFF00093, 3'd0, 1'b1);
        chk("i_uns", {32'b0, oi32}, 64'h0000_0000_0000_0FFF);
        send(32'hFE000EE3, 3'd2, 1'b0);
        send(32'h800000EF, 3'd4, 1'b0);
        chk("j_imm32", {32'b0, oi32}, 64'h0000_0000_FFF0_0000);
        send(32'hFE112E23, 3'd1, 1'b0);
        chk("s_imm32", {32'b0, oi32}, 64'h0000_0000_FFFF_FFFC);
        send(32'h000FD073, 3'd5, 1'b0);
        chk("z_imm32", {32'b0, oi32}, 64'h0000_0000_0000_001F);
        send(32'h800000B7, 3'd3, 1'b0);
        chk("u_imm64", oi64, 64'hFFFF_FFFF_8000_0000);
        send(32'h800000B7, 3'd3, 1'b1);
        chk("u_uns_imm64", oi64, 64'hFFFF_FFFF_8000_0000);
        send(32'hFFFFFFFF, 3'd6, 1'b0);
        chk("f6_err", {63'b0, oe32}, 64'd1);
        chk("f6_imm64", oi64, 64'd0);
        send(32'h12345678, 3'd7, 1'b1);
        chk("f7_err", {63'b0, oe64}, 64'd1);
        tick(); tick();

        // Backpressure: three words with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093; in_fmt = 3'd0; in_uns = 1'b0;
        tick();
        chk("bp_ready_after1", {63'b0, ir32}, 64'd1);
        in_instr  = 32'h800000EF; in_fmt = 3'd4;
        tick();
        chk("bp_ready_after2", {63'b0, ir32}, 64'd0);
        in_instr  = 32'h000FD073; in_fmt = 3'd5;
        tick(); tick();
        chk("bp_ready_held", {63'b0, ir32}, 64'd0);
        chk("bp_first_held", {32'b0, oi32}, 64'h0000_0000_FFFF_FFFF);
        out_ready = 1'b1;
        tick();
        chk("bp_second", {32'b0, oi32}, 64'h0000_0000_FFF0_0000);
        chk("bp_ready_back", {63'b0, ir32}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third", {32'b0, oi32}, 64'h0000_0000_0000_001F);
        tick();
        chk("bp_drained", {63'b0, ov32}, 64'd0);

        // Random valid/ready traffic
        start = pops;
        acc   = 1'b0;
        for (int c = 0; c < 60000 && (pops - start) < 10000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = $urandom;
                in_fmt   = 3'($urandom_range(0, 7));
                in_uns   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && ir32;
            tick();
        end
        chk("rand_count", {63'b0, ((pops - start) >= 10000)}, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rand_empty", 64'(q.size()), 64'd0);

        // Reset while FULL
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd0, 1'b0);
        send(32'h800000EF, 3'd4, 1'b0);
        chk("full_ready", {63'b0, ir32}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid32", {63'b0, ov32}, 64'd0);
        chk("async_valid64", {63'b0, ov64}, 64'd0);
        q.delete();
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {63'b0, ir32}, 64'd1);
        chk("rel_valid", {63'b0, ov32}, 64'd0);
        out_ready = 1'b1;
        send(32'hFE112E23, 3'd1, 1'b0);
        chk("rel_fresh", {32'b0, oi32}, 64'h0000_0000_FFFF_FFFC);
        tick(); tick();
        chk("rel_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
